// File: rtl/laser_point_loader.sv
// Point loader for the LASER coverage core: buffers a job of points, streams them into the core,
// then returns the core's circle centres. Optional `LASER_CYCLE_CNT_EN adds RES_CYCLES.
module laser_point_loader #(
    parameter int NUM_POINTS   = 40,
    parameter int DONE_TIMEOUT = 4096
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [3:0]  IN_X,
    input  logic [3:0]  IN_Y,
    output logic        CORE_RST,
    output logic [3:0]  CORE_X,
    output logic [3:0]  CORE_Y,
    input  logic        CORE_DONE,
    input  logic [15:0] CORE_C,
    output logic        RES_VALID,
    input  logic        RES_READY,
    output logic [15:0] RES_C,
    output logic        RES_TIMEOUT,
    output logic        BUSY
`ifdef LASER_CYCLE_CNT_EN
    ,
    output logic [15:0] RES_CYCLES
`endif
);

    localparam int IDX_W = $clog2(NUM_POINTS + 1);
    localparam int TMO_W = $clog2(DONE_TIMEOUT);

    typedef enum logic [1:0] {
        S_FILL,
        S_STREAM,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_wr_idx;
    logic [IDX_W-1:0]   r_rd_idx;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_in_ready;
    logic               r_core_rst;
    logic [3:0]         r_core_x;
    logic [3:0]         r_core_y;
    logic               r_res_valid;
    logic [15:0]        r_res_c;
    logic               r_res_timeout;
    logic               r_busy;
    logic [7:0]         r_buf [NUM_POINTS];

    logic               w_in_fire;
    logic               w_last_wr;
    logic               w_rd_last;
    logic               w_tmo_last;
    logic [IDX_W-1:0]   w_rd_next;
    logic [7:0]         w_first_pt;

    assign w_in_fire  = IN_VALID && (r_state == S_FILL);
    assign w_last_wr  = (r_wr_idx == IDX_W'(NUM_POINTS - 1));
    assign w_rd_last  = (r_rd_idx == IDX_W'(NUM_POINTS - 1));
    assign w_tmo_last = (r_tmo == TMO_W'(DONE_TIMEOUT - 1));
    // Saturating index keeps the buffer read in range on the final stream cycle.
    assign w_rd_next  = w_rd_last ? r_rd_idx : r_rd_idx + 1'b1;

    generate
        if (NUM_POINTS == 1) begin : g_bypass
            assign w_first_pt = {IN_Y, IN_X};
        end else begin : g_buffered
            assign w_first_pt = r_buf[0];
        end
    endgenerate

    // NOTE: the point buffer has no reset; every entry is rewritten before it is streamed.
    always_ff @(posedge CLK) begin
        if (w_in_fire) begin
            r_buf[r_wr_idx] <= {IN_Y, IN_X};
        end
    end

`ifdef LASER_CYCLE_CNT_EN
    logic [15:0] r_cycles;
    logic [15:0] w_cycles_inc;

    assign w_cycles_inc = (r_cycles == 16'hFFFF) ? r_cycles : r_cycles + 16'd1;
    assign RES_CYCLES   = r_cycles;
`endif

    // NOTE: reset is synchronous, so it lives inside the clocked block and is sampled at the edge.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state       <= S_FILL;
            r_wr_idx      <= '0;
            r_rd_idx      <= '0;
            r_tmo         <= '0;
            r_in_ready    <= 1'b1;
            r_core_rst    <= 1'b1;
            r_core_x      <= 4'd0;
            r_core_y      <= 4'd0;
            r_res_valid   <= 1'b0;
            r_res_c       <= 16'd0;
            r_res_timeout <= 1'b0;
            r_busy        <= 1'b0;
`ifdef LASER_CYCLE_CNT_EN
            r_cycles      <= 16'd0;
`endif
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_in_fire) begin
                        r_wr_idx <= r_wr_idx + 1'b1;
                        if (w_last_wr) begin
                            r_state                <= S_STREAM;
                            r_rd_idx               <= '0;
                            r_in_ready             <= 1'b0;
                            r_core_rst             <= 1'b0;
                            {r_core_y, r_core_x}   <= w_first_pt;
                            r_busy                 <= 1'b1;
`ifdef LASER_CYCLE_CNT_EN
                            r_cycles               <= 16'd0;
`endif
                        end
                    end
                end

                S_STREAM: begin
`ifdef LASER_CYCLE_CNT_EN
                    r_cycles <= w_cycles_inc;
`endif
                    if (w_rd_last) begin
                        r_state <= S_WAIT;
                        r_tmo   <= '0;
                    end else begin
                        r_rd_idx             <= w_rd_next;
                        {r_core_y, r_core_x} <= r_buf[w_rd_next];
                    end
                end

                S_WAIT: begin
`ifdef LASER_CYCLE_CNT_EN
                    r_cycles <= w_cycles_inc;
`endif
                    // DONE takes priority over a timeout landing on the same cycle.
                    if (CORE_DONE) begin
                        r_state       <= S_RESULT;
                        r_res_c       <= CORE_C;
                        r_res_timeout <= 1'b0;
                        r_res_valid   <= 1'b1;
                        r_core_rst    <= 1'b1;
                    end else if (w_tmo_last) begin
                        r_state       <= S_RESULT;
                        r_res_c       <= 16'd0;
                        r_res_timeout <= 1'b1;
                        r_res_valid   <= 1'b1;
                        r_core_rst    <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end

                S_RESULT: begin
                    if (RES_READY) begin
                        r_state     <= S_FILL;
                        r_res_valid <= 1'b0;
                        r_wr_idx    <= '0;
                        r_tmo       <= '0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    assign IN_READY    = r_in_ready;
    assign CORE_RST    = r_core_rst;
    assign CORE_X      = r_core_x;
    assign CORE_Y      = r_core_y;
    assign RES_VALID   = r_res_valid;
    assign RES_C       = r_res_c;
    assign RES_TIMEOUT = r_res_timeout;
    assign BUSY        = r_busy;

endmodule
